rotary_counter: RTL



---
 rtl/rotary_counter_if.sv | 15 +
 rtl/rotary_counter.sv | 118 +++++++++++
 2 files changed

// File: rtl/rotary_counter_if.sv
// Instruction, encoder-pin and read-result bundle of rotary_counter.
// Master drives instructions and pins; slave returns the registered read data and error.
interface rotary_counter_if #(
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 8
);
  logic [11:0]             inst;
  logic                    inst_en;
  logic [2*CHANNELS-1:0]   rotary;
  logic [CNT_WIDTH-1:0]    data;
  logic                    error;

  modport master (output inst, inst_en, rotary, input data, error);
  modport slave  (input inst, inst_en, rotary, output data, error);
endinterface

// File: rtl/rotary_counter.sv
// Multi-channel x4 quadrature counter; pin-to-count 3 clocks, read data valid 1 clock after inst_en.
// No backpressure: an instruction is accepted every cycle, an illegal one locks the block in Error until reset.
module rotary_counter #(
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  rotary_counter_if.slave  bus
);

  typedef enum logic [1:0] {ST_RESET, ST_READY, ST_ERROR} state_e;

  localparam logic [3:0] OP_RDC  = 4'h1;
  localparam logic [3:0] OP_RDCC = 4'h2;
  localparam logic [3:0] OP_CLR  = 4'h3;
  localparam logic [3:0] OP_RDG  = 4'h4;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [8:0]           CH_LIM  = 9'(CHANNELS);

  state_e                  state_q, state_d;
  logic [2*CHANNELS-1:0]   sync1_q, sync2_q, prev_q;
  logic [CNT_WIDTH-1:0]    cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0]     glitch_q, glitch_d;
  logic [CNT_WIDTH-1:0]    data_q, data_d;

  logic [3:0]              op;
  logic [8:0]              ch_ext;
  logic                    op_acc, bad;
  logic [CHANNELS-1:0]     inc, dec, glt, sel;

  // Gray-code position of {B,A}; forward rotation advances the position by one.
  function automatic logic [1:0] phase_pos(input logic [1:0] ba);
    case (ba)
      2'b00:   phase_pos = 2'd0;
      2'b01:   phase_pos = 2'd1;
      2'b11:   phase_pos = 2'd2;
      default: phase_pos = 2'd3;
    endcase
  endfunction

  assign op     = bus.inst[11:8];
  assign ch_ext = {1'b0, bus.inst[7:0]};
  assign op_acc = (op >= OP_RDC) && (op <= OP_RDG);
  assign bad    = bus.inst_en && ((op > OP_RDG) || (op_acc && (ch_ext >= CH_LIM)));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_dec
    logic [1:0] diff;
    assign diff   = phase_pos(sync2_q[2*g +: 2]) - phase_pos(prev_q[2*g +: 2]);
    assign inc[g] = (diff == 2'd1);
    assign dec[g] = (diff == 2'd3);
    assign glt[g] = (diff == 2'd2);
    assign sel[g] = bus.inst_en && (ch_ext == 9'(g));
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    glitch_d = glitch_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_RESET: state_d = ST_READY;
      ST_READY: begin
        if (bad) begin
          state_d = ST_ERROR;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            // Clearing reloads with this cycle's delta so a coincident step survives.
            if (sel[i] && ((op == OP_RDCC) || (op == OP_CLR))) cnt_d[i] = '0;
            if (inc[i] && !((SATURATE != 0) && (cnt_d[i] == CNT_MAX)))
              cnt_d[i] = cnt_d[i] + CNT_ONE;
            else if (dec[i] && !((SATURATE != 0) && (cnt_d[i] == CNT_MIN)))
              cnt_d[i] = cnt_d[i] - CNT_ONE;
            if (sel[i] && (op == OP_RDG)) glitch_d[i] = 1'b0;
            if (glt[i]) glitch_d[i] = 1'b1;
            if (sel[i] && ((op == OP_RDC) || (op == OP_RDCC))) data_d = cnt_q[i];
            if (sel[i] && (op == OP_RDG)) data_d = {{(CNT_WIDTH-1){1'b0}}, glitch_q[i]};
          end
        end
      end
      default: state_d = ST_ERROR;
    endcase
    if (state_d == ST_ERROR) begin
      data_d   = '0;
      glitch_d = '0;
      for (int i = 0; i < CHANNELS; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      glitch_q <= '0;
      data_q   <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.rotary;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      glitch_q <= glitch_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.data  = data_q;
  assign bus.error = (state_q == ST_ERROR);

endmodule
